// File: rtl/mcpu_boot_loader_pkg.sv
// Shared definitions for the MCPU program loader / RAM dumper.
// Defaults track the MCPU word width and RAM depth.
package mcpu_boot_loader_pkg;

  localparam int MCPU_WORD_SIZE = 16;
  localparam int MCPU_ADDR_SIZE = 8;
  localparam int MCPU_RAM_SIZE  = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_DUMP_RD  = 3'd4,
    ST_DUMP_OUT = 3'd5
  } state_t;

  function automatic logic state_busy(input state_t s);
    return (s == ST_CLEAR) || (s == ST_LOAD) || (s == ST_DUMP_RD) || (s == ST_DUMP_OUT);
  endfunction

endpackage

// File: rtl/mcpu_dump_stage.sv
// Output side of the RAM dump: presents a read word on a valid/ready stream
// and holds word and address stable while the consumer stalls.
module mcpu_dump_stage #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_rd,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_data,
  output logic [ADDR_SIZE-1:0] o_addr
);

  logic                 r_pend;
  logic                 r_held;
  logic [WORD_SIZE-1:0] r_data;
  logic [ADDR_SIZE-1:0] r_addr;

  // r_pend marks the cycle the synchronous RAM delivers the word; it is
  // passed straight through then, and captured only if the consumer stalls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend <= 1'b0;
      r_held <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
    end else begin
      r_pend <= i_rd;
      if (i_rd) r_addr <= i_addr;
      if (r_pend && !i_ready) begin
        r_data <= i_rdata;
        r_held <= 1'b1;
      end else if (r_held && i_ready) begin
        r_held <= 1'b0;
      end
    end
  end

  assign o_valid = r_pend | r_held;
  assign o_data  = r_pend ? i_rdata : r_data;
  assign o_addr  = r_addr;

endmodule

// File: rtl/mcpu_boot_loader.sv
// MCPU program loader: clears RAM, streams a program in, releases the CPU,
// and can dump the whole RAM back out over a valid/ready stream.
module mcpu_boot_loader
  import mcpu_boot_loader_pkg::*;
#(
  parameter int WORD_SIZE     = MCPU_WORD_SIZE,
  parameter int ADDR_SIZE     = MCPU_ADDR_SIZE,
  parameter int RAM_SIZE      = MCPU_RAM_SIZE,
  parameter int CLEAR_ON_LOAD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_load,
  input  logic                 start_dump,
  input  logic [ADDR_SIZE:0]   load_len,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_SIZE-1:0] out_addr,
  input  logic                 out_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WORD_SIZE-1:0] checksum
);

  localparam int CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0] LP_RAM_SIZE = CW'(RAM_SIZE);
  localparam logic [CW-1:0] LP_LAST     = CW'(RAM_SIZE - 1);

  function automatic logic [WORD_SIZE-1:0] sum_wrap(input logic [WORD_SIZE-1:0] a,
                                                     input logic [WORD_SIZE-1:0] b);
    return a + b;
  endfunction

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_len;
  logic [WORD_SIZE-1:0] r_sum;
  logic                 r_done;
  logic                 r_error;

  logic w_in_ready;
  logic w_load_fire;
  logic w_out_fire;
  logic w_dump_rd;

  assign w_in_ready  = (r_state == ST_LOAD) && (r_cnt < r_len);
  assign w_load_fire = w_in_ready && in_valid;
  assign w_out_fire  = (r_state == ST_DUMP_OUT) && out_valid && out_ready;
  assign w_dump_rd   = (r_state == ST_DUMP_RD);

  // RAM port follows the state directly so a load word is written the
  // same cycle it is accepted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_cnt[ADDR_SIZE-1:0];
      end
      ST_LOAD: begin
        mem_we    = w_load_fire;
        mem_addr  = r_cnt[ADDR_SIZE-1:0];
        mem_wdata = w_load_fire ? in_data : '0;
      end
      ST_DUMP_RD, ST_DUMP_OUT: mem_addr = r_cnt[ADDR_SIZE-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (start_load) begin
            if (load_len > LP_RAM_SIZE) begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_len   <= load_len;
              r_sum   <= '0;
              r_error <= 1'b0;
              r_cnt   <= '0;
              r_state <= (CLEAR_ON_LOAD != 0) ? ST_CLEAR : ST_LOAD;
            end
          end else if (start_dump) begin
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_DUMP_RD;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_load_fire) begin
            r_sum <= sum_wrap(r_sum, in_data);
            r_cnt <= r_cnt + 1'b1;
            if ((r_cnt + 1'b1) == r_len) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
            end
          end else if (r_cnt >= r_len) begin
            r_state <= ST_RUN;
            r_done  <= 1'b1;
          end
        end
        ST_DUMP_RD: r_state <= ST_DUMP_OUT;
        ST_DUMP_OUT: begin
          if (w_out_fire) begin
            if (r_cnt == LP_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= ST_DUMP_RD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mcpu_dump_stage #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_dump (
    .i_clk    (clk),
    .i_reset_n(reset),
    .i_rd     (w_dump_rd),
    .i_addr   (r_cnt[ADDR_SIZE-1:0]),
    .i_rdata  (mem_rdata),
    .i_ready  (out_ready),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_addr   (out_addr)
  );

  assign in_ready  = w_in_ready;
  assign cpu_reset = (r_state != ST_RUN);
  assign busy      = state_busy(r_state);
  assign done      = r_done;
  assign error     = r_error;
  assign checksum  = r_sum;

endmodule

// File: tb/tb_mcpu_boot_loader.sv
// Directed bench for mcpu_boot_loader with a behavioural synchronous RAM.
module tb_mcpu_boot_loader;

  logic        clk;
  logic        reset;
  logic        start_load;
  logic        start_dump;
  logic [8:0]  load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_addr;
  logic        out_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  mcpu_boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start_load(start_load),
    .start_dump(start_dump),
    .load_len  (load_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_ready (out_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] prog [16];
  logic [7:0]  wr_a [1024];
  logic [15:0] wr_d [1024];
  int          wr_n = 0;
  int          n_done = 0;
  logic        done_cpu = 1'b0;
  int          dump_cnt = 0;
  int          done_dump_cnt = 0;

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (wr_n < 1024) begin
        wr_a[wr_n] = mem_addr;
        wr_d[wr_n] = mem_wdata;
      end
      wr_n = wr_n + 1;
    end
    if (done === 1'b1) begin
      n_done        = n_done + 1;
      done_cpu      = cpu_reset;
      done_dump_cnt = dump_cnt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string p);
    check({p, "_in_ready"},  32'(in_ready),  0);
    check({p, "_out_valid"}, 32'(out_valid), 0);
    check({p, "_out_data"},  32'(out_data),  0);
    check({p, "_out_addr"},  32'(out_addr),  0);
    check({p, "_mem_we"},    32'(mem_we),    0);
    check({p, "_mem_addr"},  32'(mem_addr),  0);
    check({p, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({p, "_cpu_reset"}, 32'(cpu_reset), 1);
    check({p, "_busy"},      32'(busy),      0);
    check({p, "_done"},      32'(done),      0);
    check({p, "_error"},     32'(error),     0);
    check({p, "_checksum"},  32'(checksum),  0);
  endtask

  task automatic run_load(input int len, input bit toggle, input bit both, input bit poke,
                          input logic [15:0] exp_sum, input string nm);
    int k;
    int cyc;
    int d0;
    int bad;
    bit acc;
    wr_n = 0;
    d0 = n_done;
    load_len = 9'(len);
    start_load = 1'b1;
    start_dump = both;
    tick();
    start_load = 1'b0;
    start_dump = 1'b0;
    if (both) begin
      check({nm, "_arb_busy"},      32'(busy),      1);
      check({nm, "_arb_clear_we"},  32'(mem_we),    1);
      check({nm, "_arb_cpu_reset"}, 32'(cpu_reset), 1);
      check({nm, "_arb_out_valid"}, 32'(out_valid), 0);
    end
    k = 0;
    cyc = 0;
    while (n_done == d0 && cyc < 3000) begin
      start_load = poke && (cyc == 10);
      start_dump = poke && (cyc == 10);
      load_len   = (poke && cyc == 10) ? 9'd257 : 9'(len);
      in_valid   = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data    = prog[k % 16];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (poke && cyc == 11) begin
        check({nm, "_poke_error"}, 32'(error),  0);
        check({nm, "_poke_clear"}, 32'(mem_we), 1);
        check({nm, "_poke_wdata"}, 32'(mem_wdata), 0);
      end
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    load_len = 9'(len);
    check({nm, "_done_pulses"}, 32'(n_done - d0), 1);
    check({nm, "_words"},       32'(k),           32'(len));
    check({nm, "_writes"},      32'(wr_n),        32'(256 + len));
    bad = 0;
    for (int i = 0; i < 256 && i < wr_n; i++)
      if (wr_a[i] !== 8'(i) || wr_d[i] !== 16'h0) bad++;
    check({nm, "_clear_seq_bad"}, 32'(bad), 0);
    bad = 0;
    for (int j = 0; j < len && (256 + j) < wr_n; j++)
      if (wr_a[256 + j] !== 8'(j) || wr_d[256 + j] !== prog[j % 16]) bad++;
    check({nm, "_load_seq_bad"}, 32'(bad), 0);
    check({nm, "_checksum"},      32'(checksum), 32'(exp_sum));
    check({nm, "_cpu_reset_run"}, 32'(cpu_reset), 0);
    check({nm, "_done_cpu_rst"},  32'(done_cpu),  0);
    check({nm, "_error"},         32'(error),     0);
    check({nm, "_in_ready_run"},  32'(in_ready),  0);
  endtask

  typedef struct {
    int          len;
    bit          toggle;
    bit          exp_err;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int d0;
    int k;
    int cyc;
    int bad;
    int stall;
    bit acc;
    bit drop;
    bit raise;
    logic [15:0] expw;

    prog[0]  = 16'h1101; prog[1]  = 16'h2202; prog[2]  = 16'h3303; prog[3]  = 16'h4404;
    prog[4]  = 16'h5505; prog[5]  = 16'h6606; prog[6]  = 16'h7707; prog[7]  = 16'h8808;
    prog[8]  = 16'h9909; prog[9]  = 16'hAA0A; prog[10] = 16'hBB0B; prog[11] = 16'hCC0C;
    prog[12] = 16'hDD0D; prog[13] = 16'hEE0E; prog[14] = 16'hFF0F; prog[15] = 16'h0010;

    vecs[0] = '{len: 16,  toggle: 1'b0, exp_err: 1'b0, exp_sum: 16'hF888};
    vecs[1] = '{len: 257, toggle: 1'b0, exp_err: 1'b1, exp_sum: 16'h0000};
    vecs[2] = '{len: 0,   toggle: 1'b0, exp_err: 1'b0, exp_sum: 16'h0000};
    vecs[3] = '{len: 4,   toggle: 1'b1, exp_err: 1'b0, exp_sum: 16'hAA0A};
    vecs[4] = '{len: 1,   toggle: 1'b1, exp_err: 1'b0, exp_sum: 16'h1101};
    vecs[5] = '{len: 7,   toggle: 1'b1, exp_err: 1'b0, exp_sum: 16'hDC1C};

    reset = 1'b0;
    start_load = 1'b0;
    start_dump = 1'b0;
    load_len = 9'd0;
    in_valid = 1'b0;
    in_data = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_rst("rst");
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_err) begin
        wr_n = 0;
        d0 = n_done;
        load_len = 9'(vecs[v].len);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check($sformatf("vec%0d_rej_error", v),     32'(error),     1);
        check($sformatf("vec%0d_rej_cpu_reset", v), 32'(cpu_reset), 1);
        check($sformatf("vec%0d_rej_busy", v),      32'(busy),      0);
        check($sformatf("vec%0d_rej_in_ready", v),  32'(in_ready),  0);
        repeat (3) tick();
        check($sformatf("vec%0d_rej_writes", v), 32'(wr_n),          0);
        check($sformatf("vec%0d_rej_done", v),   32'(n_done - d0),   0);
        check($sformatf("vec%0d_rej_sticky", v), 32'(error),         1);
      end else begin
        run_load(vecs[v].len, vecs[v].toggle, 1'b0, 1'b0, vecs[v].exp_sum,
                 $sformatf("vec%0d", v));
      end
    end

    // Load and dump requested together in RUN; starts poked again mid-clear.
    run_load(16, 1'b0, 1'b1, 1'b1, 16'hF888, "arb");

    // Full dump with the consumer stalling on word 5.
    d0 = n_done;
    dump_cnt = 0;
    bad = 0;
    stall = 0;
    drop = 1'b0;
    raise = 1'b0;
    out_ready = 1'b1;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    check("dump_cpu_reset", 32'(cpu_reset), 1);
    check("dump_busy",      32'(busy),      1);
    cyc = 0;
    while (dump_cnt < 256 && cyc < 3000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        expw = (dump_cnt < 16) ? prog[dump_cnt] : 16'h0;
        if (out_addr !== 8'(dump_cnt) || out_data !== expw || out_data !== ram[out_addr]) bad++;
        if (out_addr == 8'd4) drop = 1'b1;
        dump_cnt++;
      end else if (out_valid && !out_ready) begin
        stall++;
        check($sformatf("stall%0d_addr", stall), 32'(out_addr), 5);
        check($sformatf("stall%0d_data", stall), 32'(out_data), 32'(prog[5]));
        if (stall == 3) raise = 1'b1;
      end
      @(posedge clk);
      #1;
      if (drop) begin out_ready = 1'b0; drop = 1'b0; end
      if (raise) begin out_ready = 1'b1; raise = 1'b0; end
      cyc++;
    end
    for (int i = 0; i < 4 && n_done == d0; i++) tick();
    check("dump_words",       32'(dump_cnt),      256);
    check("dump_data_bad",    32'(bad),           0);
    check("dump_stall_cycles",32'(stall),         3);
    check("dump_done_pulses", 32'(n_done - d0),   1);
    check("dump_done_after",  32'(done_dump_cnt), 256);
    check("dump_done_cpu",    32'(done_cpu),      1);
    check("dump_end_busy",    32'(busy),          0);
    check("dump_end_cpu_rst", 32'(cpu_reset),     1);

    // Asynchronous reset in the middle of a load, at word 7.
    wr_n = 0;
    load_len = 9'd16;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 7 && cyc < 1000) begin
      in_valid = 1'b1;
      in_data = prog[k];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    check("midrst_words_before", 32'(k), 7);
    check("midrst_we_before", 32'(mem_we), 1);
    #2;
    reset = 1'b0;
    #1;
    check_rst("midrst");
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_load(16, 1'b0, 1'b0, 1'b0, 16'hF888, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
